// File: rtl/obi_mux_n_to_1.sv
// Purpose: N-to-1 OBI mux with fixed-priority or round-robin arbitration, an address-phase lock and in-order response routing.
// Latency: zero added cycles; grant and response are combinational passthroughs.
// Backpressure: the shared request is withheld while the response-tracking FIFO is full, unless a response pops an entry in the same cycle.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   mst_*_i / mst_*_o   NUM_MASTERS flattened OBI master ports (master k at slice k)
//   shr_*_o / shr_*_i   single shared OBI slave port
//   busy_o              at least one tracked transaction is outstanding
module obi_mux_n_to_1 #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0,
    parameter int WRITE_RESP      = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          mst_req_i,
    output logic [NUM_MASTERS-1:0]          mst_gnt_o,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   mst_addr_i,
    input  logic [NUM_MASTERS-1:0]          mst_we_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] mst_be_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   mst_wdata_i,
    output logic [NUM_MASTERS-1:0]          mst_rvalid_o,
    output logic [NUM_MASTERS*DATA_W-1:0]   mst_rdata_o,
    output logic                            shr_req_o,
    input  logic                            shr_gnt_i,
    output logic [ADDR_W-1:0]               shr_addr_o,
    output logic                            shr_we_o,
    output logic [DATA_W/8-1:0]             shr_be_o,
    output logic [DATA_W-1:0]               shr_wdata_o,
    input  logic                            shr_rvalid_i,
    input  logic [DATA_W-1:0]               shr_rdata_i,
    output logic                            busy_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_W / 8;

    // Response-tracking FIFO: holds the master index of each outstanding access.
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Arbitration state.
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             can_accept;
    logic             handshake;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;

    // Winner selection. A pending lock pins the selection so the slave sees
    // stable address-phase signals until it grants.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        if (lock_q) begin
            sel_vld = mst_req_i[lock_idx_q];
            sel_idx = lock_idx_q;
        end else if (ARB_MODE == 0) begin
            // Descending scan: the last hit is the lowest requesting index.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (mst_req_i[i]) begin
                    sel_vld = 1'b1;
                    sel_idx = IDX_W'(i);
                end
            end
        end else begin
            // Descending offset scan from the RR pointer: the last hit is the
            // first requester at or after the pointer, modulo NUM_MASTERS.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                int j;
                j = int'(rr_q) + i;
                if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
                if (mst_req_i[IDX_W'(j)]) begin
                    sel_vld = 1'b1;
                    sel_idx = IDX_W'(j);
                end
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_accept = (count_q < CNT_W'(MAX_OUTSTANDING)) || (shr_rvalid_i && (count_q != '0));
    assign shr_req_o  = sel_vld && can_accept;
    assign handshake  = shr_req_o && shr_gnt_i;
    assign push       = handshake && ((WRITE_RESP != 0) || !mst_we_i[sel_idx]);
    assign pop        = shr_rvalid_i && (count_q != '0);
    assign head_idx   = fifo_q[rptr_q];
    assign busy_o     = (count_q != '0);

    // Address-phase mux; zero when nobody is selected.
    always_comb begin
        shr_addr_o  = '0;
        shr_we_o    = 1'b0;
        shr_be_o    = '0;
        shr_wdata_o = '0;
        mst_gnt_o   = '0;
        if (sel_vld) begin
            shr_addr_o  = mst_addr_i[sel_idx*ADDR_W +: ADDR_W];
            shr_we_o    = mst_we_i[sel_idx];
            shr_be_o    = mst_be_i[sel_idx*BE_W +: BE_W];
            shr_wdata_o = mst_wdata_i[sel_idx*DATA_W +: DATA_W];
        end
        if (handshake) mst_gnt_o[sel_idx] = 1'b1;
    end

    // Response routing to the oldest outstanding master; stray responses are dropped.
    always_comb begin
        mst_rvalid_o = '0;
        mst_rdata_o  = '0;
        if (pop) begin
            mst_rvalid_o[head_idx]                  = 1'b1;
            mst_rdata_o[head_idx*DATA_W +: DATA_W]  = shr_rdata_i;
        end
    end

    // Next-state logic.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;

        if (push) wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;

        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // Lock on an unanswered request; a gated request leaves the lock as is.
        if (handshake) begin
            lock_d = 1'b0;
        end else if (shr_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end

        if ((ARB_MODE == 1) && handshake)
            rr_d = (sel_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
        end
    end

    // FIFO storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= sel_idx;
    end

endmodule

// File: tb/tb_obi_mux_n_to_1.sv
// Purpose: directed bench for obi_mux_n_to_1; one fixed-priority and one round-robin instance share stimulus.
// Latency: checks combinational grant/response in the same cycle as the stimulus.
// Backpressure: exercises FIFO-full gating and simultaneous push/pop.
module tb_obi_mux_n_to_1;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] addr;
    logic [3:0]   we;
    logic [15:0]  be;
    logic [127:0] wdata;
    logic         gnt;
    logic         rvalid;
    logic [31:0]  rdata;

    // Instance a: fixed priority, 2 outstanding, reads only tracked.
    logic [3:0]   a_gnt, a_rvalid;
    logic [127:0] a_rdata;
    logic         a_sreq, a_swe, a_busy;
    logic [31:0]  a_saddr, a_swdata;
    logic [3:0]   a_sbe;
    // Instance b: round robin, 4 outstanding, writes tracked.
    logic [3:0]   b_gnt, b_rvalid;
    logic [127:0] b_rdata;
    logic         b_sreq, b_swe, b_busy;
    logic [31:0]  b_saddr, b_swdata;
    logic [3:0]   b_sbe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obi_mux_n_to_1 #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2),
                     .ARB_MODE(0), .WRITE_RESP(0)) u_a (
        .clk_i(clk), .rst_i(rst), .mst_req_i(req), .mst_gnt_o(a_gnt), .mst_addr_i(addr),
        .mst_we_i(we), .mst_be_i(be), .mst_wdata_i(wdata), .mst_rvalid_o(a_rvalid),
        .mst_rdata_o(a_rdata), .shr_req_o(a_sreq), .shr_gnt_i(gnt), .shr_addr_o(a_saddr),
        .shr_we_o(a_swe), .shr_be_o(a_sbe), .shr_wdata_o(a_swdata), .shr_rvalid_i(rvalid),
        .shr_rdata_i(rdata), .busy_o(a_busy));

    obi_mux_n_to_1 #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4),
                     .ARB_MODE(1), .WRITE_RESP(1)) u_b (
        .clk_i(clk), .rst_i(rst), .mst_req_i(req), .mst_gnt_o(b_gnt), .mst_addr_i(addr),
        .mst_we_i(we), .mst_be_i(be), .mst_wdata_i(wdata), .mst_rvalid_o(b_rvalid),
        .mst_rdata_o(b_rdata), .shr_req_o(b_sreq), .shr_gnt_i(gnt), .shr_addr_o(b_saddr),
        .shr_we_o(b_swe), .shr_be_o(b_sbe), .shr_wdata_o(b_swdata), .shr_rvalid_i(rvalid),
        .shr_rdata_i(rdata), .busy_o(b_busy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; we = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (a_gnt !== 4'h0) begin errors++; $display("FAIL rst_gnt got=%h exp=0", a_gnt); end
        checks++; if (a_rvalid !== 4'h0 || a_rdata !== 128'h0) begin errors++; $display("FAIL rst_rvalid got=%h/%h exp=0", a_rvalid, a_rdata); end
        checks++; if (a_sreq !== 1'b0 || a_saddr !== 32'h0 || a_swe !== 1'b0 || a_sbe !== 4'h0 || a_swdata !== 32'h0) begin
            errors++; $display("FAIL rst_shr got req=%b addr=%h exp all 0", a_sreq, a_saddr); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b%b exp=00", a_busy, b_busy); end
    endtask

    task automatic test_priority;
        logic [127:0] exp_rd;
        do_reset();
        req = 4'b1010; gnt = 1'b1; #1;
        checks++; if (a_gnt !== 4'b0010) begin errors++; $display("FAIL fp_gnt got=%b exp=0010", a_gnt); end
        checks++; if (a_saddr !== 32'hA000_0010) begin errors++; $display("FAIL fp_addr got=%h exp=a0000010", a_saddr); end
        tick();
        req = '0; gnt = 1'b0; #1;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL fp_busy got=%b exp=1", a_busy); end
        rvalid = 1'b1; rdata = 32'hDEADBEEF; #1;
        exp_rd = '0; exp_rd[63:32] = 32'hDEADBEEF;
        checks++; if (a_rvalid !== 4'b0010) begin errors++; $display("FAIL fp_rvalid got=%b exp=0010", a_rvalid); end
        checks++; if (a_rdata !== exp_rd) begin errors++; $display("FAIL fp_rdata got=%h exp=%h", a_rdata, exp_rd); end
        tick();
        rvalid = 1'b0; #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL fp_drain got=%b exp=0", a_busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg, er;
        do_reset();
        gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req = (c < 5) ? 4'hF : 4'h0;
            rvalid = (c > 0);
            rdata = 32'h100 + c;
            #1;
            eg = (c < 5) ? 4'(1 << (c % 4)) : 4'h0;
            checks++; if (b_gnt !== eg) begin errors++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, b_gnt, eg); end
            if (c > 0) begin
                er = 4'(1 << ((c - 1) % 4));
                checks++; if (b_rvalid !== er) begin errors++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, b_rvalid, er); end
            end
            tick();
        end
        rvalid = 1'b0; gnt = 1'b0; #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rr_busy got=%b exp=0", b_busy); end
    endtask

    task automatic test_lock;
        do_reset();
        req = 4'b0100; gnt = 1'b0; #1;
        checks++; if (a_saddr !== 32'hA000_0020) begin errors++; $display("FAIL lk_first got=%h exp=a0000020", a_saddr); end
        tick();
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (a_saddr !== 32'hA000_0020 || a_gnt !== 4'h0) begin
                errors++; $display("FAIL lk_hold c=%0d got addr=%h gnt=%b exp=a0000020/0000", c, a_saddr, a_gnt); end
            tick();
        end
        gnt = 1'b1; #1;
        checks++; if (a_gnt !== 4'b0100) begin errors++; $display("FAIL lk_gnt got=%b exp=0100", a_gnt); end
        tick();
        #1;
        checks++; if (a_gnt !== 4'b0001 || a_saddr !== 32'hA000_0000) begin
            errors++; $display("FAIL lk_next got gnt=%b addr=%h exp=0001/a0000000", a_gnt, a_saddr); end
        tick();
        req = '0; gnt = 1'b0; rvalid = 1'b1; #1;
        checks++; if (a_rvalid !== 4'b0100) begin errors++; $display("FAIL lk_rsp0 got=%b exp=0100", a_rvalid); end
        tick();
        #1;
        checks++; if (a_rvalid !== 4'b0001) begin errors++; $display("FAIL lk_rsp1 got=%b exp=0001", a_rvalid); end
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_outstanding;
        do_reset();
        req = 4'b0010; gnt = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (a_sreq !== 1'b0 || a_gnt !== 4'h0 || a_busy !== 1'b1) begin
            errors++; $display("FAIL os_full got req=%b gnt=%b busy=%b exp=0/0000/1", a_sreq, a_gnt, a_busy); end
        rvalid = 1'b1; rdata = 32'h11; #1;
        checks++; if (a_sreq !== 1'b1 || a_gnt !== 4'b0010) begin
            errors++; $display("FAIL os_swap got req=%b gnt=%b exp=1/0010", a_sreq, a_gnt); end
        checks++; if (a_rvalid !== 4'b0010 || a_rdata[63:32] !== 32'h11) begin
            errors++; $display("FAIL os_pop got rv=%b rd=%h exp=0010/11", a_rvalid, a_rdata[63:32]); end
        tick();
        rvalid = 1'b0; #1;
        checks++; if (a_sreq !== 1'b0) begin errors++; $display("FAIL os_still_full got=%b exp=0", a_sreq); end
        req = '0; gnt = 1'b0; rvalid = 1'b1;
        tick();
        tick();
        rvalid = 1'b0; #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL os_drain got=%b exp=0", a_busy); end
    endtask

    task automatic test_write_resp;
        do_reset();
        req = 4'b0010; we = 4'b0010; gnt = 1'b1; #1;
        checks++; if (a_gnt !== 4'b0010 || b_gnt !== 4'b0010 || a_swe !== 1'b1) begin
            errors++; $display("FAIL wr_gnt got a=%b b=%b we=%b exp=0010/0010/1", a_gnt, b_gnt, a_swe); end
        tick();
        req = '0; we = '0; gnt = 1'b0; #1;
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b1) begin
            errors++; $display("FAIL wr_busy got a=%b b=%b exp=0/1", a_busy, b_busy); end
        rvalid = 1'b1; rdata = 32'h5A5A; #1;
        checks++; if (b_rvalid !== 4'b0010 || a_rvalid !== 4'h0) begin
            errors++; $display("FAIL wr_rsp got b=%b a=%b exp=0010/0000", b_rvalid, a_rvalid); end
        tick();
        rvalid = 1'b0; #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL wr_drain got=%b exp=0", b_busy); end
    endtask

    task automatic test_stray_and_reset;
        do_reset();
        rvalid = 1'b1; rdata = 32'hCAFE; #1;
        checks++; if (a_rvalid !== 4'h0 || a_rdata !== 128'h0 || b_rvalid !== 4'h0) begin
            errors++; $display("FAIL stray got a=%b b=%b exp=0000", a_rvalid, b_rvalid); end
        tick();
        rvalid = 1'b0; #1;
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL stray_busy got=%b%b exp=00", a_busy, b_busy); end
        req = 4'b0001; gnt = 1'b1;
        tick();
        tick();
        req = '0; gnt = 1'b0; #1;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mr_busy got=%b exp=1", a_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mr_clear got=%b exp=0", a_busy); end
        rvalid = 1'b1; #1;
        checks++; if (a_rvalid !== 4'h0) begin errors++; $display("FAIL mr_drop got=%b exp=0000", a_rvalid); end
        tick();
        rvalid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            addr[k*32 +: 32]  = 32'hA000_0000 + 32'(k * 16);
            wdata[k*32 +: 32] = 32'hD000_0000 + 32'(k);
        end
        be = 16'hFFFF;
        test_reset();
        test_priority();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_write_resp();
        test_stray_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
